// File: rtl/rr_mux_pkg.sv
// Shared constants and types for the 4-channel round-robin mux.
package rr_mux_pkg;
  localparam int N_CH  = 4;
  localparam int IDX_W = 2;

  typedef logic [IDX_W-1:0] ch_idx_t;

  function automatic logic [N_CH-1:0] idx2oh(input ch_idx_t idx);
    idx2oh      = '0;
    idx2oh[idx] = 1'b1;
  endfunction
endpackage

// File: rtl/rr_pick_4.sv
// Combinational round-robin picker: first valid channel at or after ptr (mod 4).
module rr_pick_4
  import rr_mux_pkg::*;
(
  input  logic [N_CH-1:0] valid,
  input  ch_idx_t         ptr,
  output logic            grant_any,
  output ch_idx_t         grant_idx
);

  ch_idx_t cand;

  // Scan from the farthest offset down so the nearest valid channel wins last.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = ptr;
    cand      = ptr;
    for (int k = N_CH-1; k >= 0; k--) begin
      cand = ptr + k[IDX_W-1:0];
      if (valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

endmodule

// File: rtl/rr_mux_4_1.sv
// 4:1 round-robin mux with a one-word registered output stage and transfer counter.
module rr_mux_4_1
  import rr_mux_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4*WIDTH-1:0]   in_data,
  input  logic [3:0]           in_valid,
  output logic [3:0]           in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [1:0]           out_sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_W-1:0]     xfer_cnt
);

  ch_idx_t ptr;
  ch_idx_t grant_idx;
  logic    grant_any;
  logic    load_en;
  logic    take;

  rr_pick_4 u_pick (
    .valid     (in_valid),
    .ptr       (ptr),
    .grant_any (grant_any),
    .grant_idx (grant_idx)
  );

  assign load_en = !out_valid || out_ready;
  assign take    = grant_any && load_en;
  // Reset gating keeps every ready low while rst_n is held.
  assign in_ready = (take && rst_n) ? idx2oh(grant_idx) : 4'b0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_sel   <= '0;
      out_valid <= 1'b0;
      ptr       <= '0;
      xfer_cnt  <= '0;
    end else if (load_en) begin
      if (grant_any) begin
        out_data  <= in_data[int'(grant_idx)*WIDTH +: WIDTH];
        out_sel   <= grant_idx;
        out_valid <= 1'b1;
        ptr       <= grant_idx + 1'b1;
        xfer_cnt  <= xfer_cnt + 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
